// File: rtl/shift_sequencer.sv
// Iterative six-stage log shifter (SLL/SRL/SRA) with valid/ready handshakes.
// Define SHIFT_WORD_OPS_EN to add the in_word port for 32-bit W-variant shifts.
module shift_sequencer #(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
`ifdef SHIFT_WORD_OPS_EN
    input  logic               in_word,
`endif
    input  logic [XLEN-1:0]    in_a,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_result,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [2:0]         k_q;
    logic [XLEN-1:0]    acc_q;
    logic [1:0]         op_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic               fill_q;
    logic               word_q;
    logic               word_in;
    logic               accept;

    logic [SHAMT_W-1:0] sh;
    logic [2*XLEN-1:0]  wide_r;
    logic [63:0]        word_r;
    logic [XLEN-1:0]    stage_res;
    logic [XLEN-1:0]    next_acc;

`ifdef SHIFT_WORD_OPS_EN
    assign word_in = in_word;
`else
    assign word_in = 1'b0;
`endif

    assign accept    = in_valid & in_ready;
    assign in_ready  = (state_q == IDLE) |
                       ((state_q == DONE) & out_ready);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_result = acc_q;

    // One log-shift stage; right shifts pull in the latched fill bit.
    always_comb begin
        sh = '0;
        if (shamt_q[k_q])
            sh = SHAMT_W'(6'd1 << k_q);
        wide_r = {{XLEN{fill_q}}, acc_q} >> sh;
        word_r = {{32{fill_q}}, acc_q[31:0]} >> sh;
        stage_res = acc_q << sh;
        if (op_q[0]) begin
            if (word_q)
                stage_res = {32'b0, word_r[31:0]};
            else
                stage_res = wide_r[XLEN-1:0];
        end
        next_acc = stage_res;
        if (word_q && (k_q == 3'd5))
            next_acc = {{32{stage_res[31]}}, stage_res[31:0]};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept)
                    state_d = SHIFT;
            end
            SHIFT: begin
                if (k_q == 3'd5)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = in_valid ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            shamt_q <= '0;
            fill_q  <= 1'b0;
            word_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= in_op;
                word_q <= word_in;
                k_q    <= '0;
                if (word_in) begin
                    shamt_q <= {1'b0, in_shamt[4:0]};
                    acc_q   <= {32'b0, in_a[31:0]};
                    fill_q  <= (in_op == 2'b11) & in_a[31];
                end else begin
                    shamt_q <= in_shamt;
                    acc_q   <= in_a;
                    fill_q  <= (in_op == 2'b11) & in_a[XLEN-1];
                end
            end else if (state_q == SHIFT) begin
                acc_q <= next_acc;
                k_q   <= k_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed vectors, queued expectations,
// a monitor checks result and fixed latency at each output handshake.
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_word;
    logic [63:0] in_a;
    logic [5:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        busy;

    shift_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
`ifdef SHIFT_WORD_OPS_EN
        .in_word    (in_word),
`endif
        .in_a       (in_a),
        .in_shamt   (in_shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    typedef struct {
        logic [63:0] res;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: latency on out_valid rise, result on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
        end else begin
            if (out_valid && !seen) begin
                seen = 1;
                if (q.size() == 0)
                    fail("unexpected_output");
                else
                    chk({q[0].name, "_lat"}, 64'(cyc - q[0].acc_cyc), 64'd6);
            end
            if (out_valid && out_ready) begin
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk(e.name, out_result, e.res);
                end
                seen = 0;
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(string name, logic [1:0] op, logic w,
                         logic [63:0] a, logic [5:0] s, logic [63:0] exp);
        int n;
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_word  = w;
        in_a     = a;
        in_shamt = s;
        n = 0;
        #1;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 100) fail({name, "_accept_timeout"});
        e.res     = exp;
        e.acc_cyc = cyc + 1;
        e.name    = name;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = '0;
        in_shamt = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) fail("drain_timeout");
    endtask

    initial begin
        logic [63:0] snap;
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_word   = 1'b0;
        in_a      = '0;
        in_shamt  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue("sll_1_63", 2'b00, 0, 64'h1, 6'd63, 64'h8000_0000_0000_0000);
        wait_idle();
        issue("sra_msb_4", 2'b11, 0, 64'h8000_0000_0000_0000, 6'd4,
              64'hF800_0000_0000_0000);
        wait_idle();
        issue("srl_msb_4", 2'b01, 0, 64'h8000_0000_0000_0000, 6'd4,
              64'h0800_0000_0000_0000);
        wait_idle();
        issue("rsv_msb_4", 2'b10, 0, 64'h8000_0000_0000_0000, 6'd4,
              64'h0);
        wait_idle();
        issue("sll_z", 2'b00, 0, 64'h1234_5678_9ABC_DEF0, 6'd0,
              64'h1234_5678_9ABC_DEF0);
        wait_idle();
        issue("srl_z", 2'b01, 0, 64'h1234_5678_9ABC_DEF0, 6'd0,
              64'h1234_5678_9ABC_DEF0);
        wait_idle();
        issue("sra_z", 2'b11, 0, 64'h1234_5678_9ABC_DEF0, 6'd0,
              64'h1234_5678_9ABC_DEF0);
        wait_idle();
        issue("rsv_z", 2'b10, 0, 64'h1234_5678_9ABC_DEF0, 6'd0,
              64'h1234_5678_9ABC_DEF0);
        wait_idle();
        issue("sra_pos_60", 2'b11, 0, 64'h7000_0000_0000_0000, 6'd60,
              64'h7);
        wait_idle();
        issue("srl_ones_63", 2'b01, 0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63,
              64'h1);
        wait_idle();
        issue("sra_ones_63", 2'b11, 0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63,
              64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle();
        issue("sll_f0_36", 2'b00, 0, 64'hF0, 6'd36,
              64'h0000_0F00_0000_0000);
        wait_idle();

        // Backpressure then same-cycle handshake and accept.
        out_ready = 1'b0;
        issue("srl_bp", 2'b01, 0, 64'hFF00, 6'd8, 64'hFF);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) fail("bp_valid_timeout");
        snap = out_result;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_result", out_result, snap);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_busy", 64'(busy), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        issue("sll_b2b", 2'b00, 0, 64'h3, 6'd1, 64'h6);
        wait_idle();

        // Asynchronous reset while k=3.
        issue("sll_killed", 2'b00, 0, 64'h1, 6'd5, 64'h20);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_result", out_result, 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        issue("sll_after_rst", 2'b00, 0, 64'h1, 6'd8, 64'h100);
        wait_idle();

`ifdef SHIFT_WORD_OPS_EN
        issue("sraw", 2'b11, 1, 64'h0000_0000_8000_0000, 6'h24,
              64'hFFFF_FFFF_F800_0000);
        wait_idle();
        issue("sllw", 2'b00, 1, 64'h1, 6'd31, 64'hFFFF_FFFF_8000_0000);
        wait_idle();
        issue("srlw", 2'b01, 1, 64'hFFFF_FFFF_8000_0000, 6'd31, 64'h1);
        wait_idle();
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
